mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer sharing one pipelined 8x8 multiplier (fixed latency, no reset, no stall) among NREQ requesters.
- Accepts at most one operand pair per cycle, drives the multiplier operand inputs and carries requester ID through a tag pipeline matched to the multiplier latency.
- Routes each product back to its originator and enforces a per-requester outstanding-operation limit.
- Sits between the requester blocks and the multiplier instance.

Parameters:
- NREQ, 4, number of requesters; ID width IDW = clog2(NREQ), derived.
- LAT, 8, multiplier latency in clk edges from operands presented to result valid.
- MAX_OUT, 3, maximum in-flight operations per requester; counter width clog2(MAX_OUT+1).

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_a  in  8*NREQ  operand A per requester (unsigned), slice i = [8i+7:8i]
- req_b  in  8*NREQ  operand B per requester (signed two's complement)
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i] are sampled high
- mul_n1  out  8  multiplier operand n1 (registered)
- mul_n2  out  8  multiplier operand n2 (registered)
- mul_result  in  16  multiplier product
- rsp_valid  out  NREQ  one-cycle one-hot response strobe (registered)
- rsp_id  out  IDW  requester index of current response (registered)
- rsp_data  out  16  product (registered)
- busy  out  1  high while any operation is in flight

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. No other asynchronous inputs.
- Reset values: req_ready=0 (forced low while rst high), mul_n1=0, mul_n2=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer=0, all outstanding counters=0, all tag-pipeline valid bits=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUT.
- Arbitration is combinational from req_valid, the RR pointer and the counters. Priority order is ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready has at most one bit set, at the first eligible index.
  - req_ready is all-zero when none are eligible.
- On a grant to i: mul_n1<=req_a[i], mul_n2<=req_b[i], and ptr<=(i+1) mod NREQ. With no grant, ptr, mul_n1 and mul_n2 hold.
- Requesters hold operands stable while req_valid is high and not granted. The arbiter neither stores nor reorders pending requests.
- Tag pipeline: LAT+1 stages of {valid, id}.
  - Stage 0 loads {1, i} on a grant and {0, x} otherwise.
  - Aligned so the final stage is valid exactly when mul_result holds that op's product.
- Response: at the edge where the final tag stage is valid, rsp_valid<=onehot(id), rsp_id<=id, rsp_data<=mul_result. Otherwise rsp_valid<=0 and rsp_id/rsp_data hold.
  - Total latency: transfer at edge E gives rsp_valid high in the cycle following edge E+LAT+1.
  - Responses return in grant order.
  - There is no response backpressure; requesters must accept the strobe.
- Outstanding counters:
  - +1 on a grant to i; -1 on a response to i.
  - Both in the same edge leaves the count unchanged.
  - A requester at MAX_OUT whose response retires in cycle C is eligible again in cycle C+1 (ready uses the registered count).
  - A counter never exceeds MAX_OUT and never underflows. A decrement at 0 is an internal error and must be flagged by assertion.
- busy = OR of all tag valid bits, including the response register stage.
- Product arithmetic belongs to the multiplier. The arbiter passes mul_result unmodified, including the zero-operand case (product 0).
- Reset mid-operation: all tag valids and counters clear. Products still inside the un-reset multiplier are discarded, and no rsp_valid is ever raised for them. Normal grants resume in the first cycle after rst deasserts.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0, mul_n1=mul_n2=0. After release, the first grant goes to requester 0.
- Single op: req0 a=8'd5, b=8'hFD (-3), accepted at edge E -> rsp_valid=4'b0001, rsp_id=0, rsp_data=16'hFFF1 in the cycle after edge E+9; busy low one cycle later.
- Full load: req_valid=4'b1111 continuously, distinct operands -> grants 0,1,2,3,0,1,... one per cycle; responses in the same order with correct products, a one-hot strobe every cycle after fill.
- Credit limit: only req1 valid continuously -> granted 3 consecutive cycles, then req_ready[1]=0 until the first response. Thereafter one regrant per retirement; outstanding[1] never exceeds 3.
- RR pointer: grant to req2 then req_valid=4'b1001 -> req3 granted before req0. With req_valid=4'b0001 only, req0 is granted regardless of pointer.
- Reset in flight: two ops outstanding on req0, rst pulsed 1 cycle -> no rsp_valid for either; counters 0. A new req0 op issued the cycle after release returns a correct product after LAT+1.

Source files
------------

// File: rtl/mult_share_arb_if.sv
// -----------------------------------------------------------------------------
// mult_share_arb_if
// Requester-side bundle of the shared-multiplier arbiter.
//   req_valid  per-requester request strobe
//   req_a      operand A per requester (unsigned), slice i = [8i+7:8i]
//   req_b      operand B per requester (signed),   slice i = [8i+7:8i]
//   req_ready  one-hot grant from the arbiter
//   rsp_valid  one-hot one-cycle response strobe
//   rsp_id     index of the requester owning the current response
//   rsp_data   16-bit product
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mult_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
// Round-robin arbiter/sequencer sharing one fixed-latency pipelined 8x8
// multiplier between NREQ requesters. One operand pair is accepted per cycle,
// the requester id rides a tag pipeline matched to the multiplier latency,
// and each product is routed back to its originator. Each requester may have
// at most MAX_OUT operations in flight.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        requester bundle (slave side): req_valid/req_a/req_b/req_ready,
//              rsp_valid/rsp_id/rsp_data
//   mul_n1     registered multiplier operand (unsigned A)
//   mul_n2     registered multiplier operand (signed B)
//   mul_result multiplier product, valid LAT edges after operands presented
//   busy       high while any operation is in flight
// -----------------------------------------------------------------------------
module mult_share_arb #(
    parameter int NREQ    = 4,
    parameter int LAT     = 8,
    parameter int MAX_OUT = 3
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_arb_if.slave   bus,
    output logic [7:0]        mul_n1,
    output logic [7:0]        mul_n2,
    input  logic [15:0]       mul_result,
    output logic              busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    logic [IDW-1:0]        ptr_q;
    logic [CW-1:0]         cnt_q [NREQ];
    logic [CW-1:0]         cnt_d [NREQ];
    logic [LAT:0]          tag_vld_q;
    logic [IDW-1:0]        tag_id_q [LAT+1];
    logic [7:0]            n1_q;
    logic signed [7:0]     n2_q;
    logic [NREQ-1:0]       rsp_valid_q;
    logic [IDW-1:0]        rsp_id_q;
    logic [15:0]           rsp_data_q;

    logic [NREQ-1:0]       elig;
    logic [NREQ-1:0]       gnt;
    logic                  gnt_any;
    logic [IDW-1:0]        gnt_id;
    logic                  fin_vld;
    logic [IDW-1:0]        fin_id;

    assign fin_vld = tag_vld_q[LAT];
    assign fin_id  = tag_id_q[LAT];

    // Eligibility looks at the registered count, so a slot freed by a
    // retirement becomes usable one cycle later.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] && (cnt_q[i] < CW'(MAX_OUT));
        end
    end

    // Scan starting at the RR pointer; first eligible index wins.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_any && elig[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                gnt_any  = 1'b1;
            end
        end
        if (rst) begin
            gnt     = '0;
            gnt_any = 1'b0;
        end
    end

    // Grant and retirement to the same requester in one edge cancel out.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && !(fin_vld && fin_id == IDW'(i))) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!gnt[i] && fin_vld && fin_id == IDW'(i)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // Stage 0 (operand register + tag entry) through response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            n1_q        <= '0;
            n2_q        <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                n1_q  <= bus.req_a[int'(gnt_id)*8 +: 8];
                n2_q  <= $signed(bus.req_b[int'(gnt_id)*8 +: 8]);
                ptr_q <= IDW'((int'(gnt_id) + 1) % NREQ);
            end
            tag_vld_q <= {tag_vld_q[LAT-1:0], gnt_any};
            if (fin_vld) begin
                rsp_valid_q <= onehot(fin_id);
                rsp_id_q    <= fin_id;
                rsp_data_q  <= mul_result;
            end else begin
                rsp_valid_q <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Tag ids are qualified by tag_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int k = 1; k <= LAT; k++) begin
            tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign mul_n1        = n1_q;
    assign mul_n2        = n2_q;
    assign busy          = (|tag_vld_q) | (|rsp_valid_q);

    // A retirement for a requester with nothing outstanding means the tag
    // pipeline and the counters have diverged.
    for (genvar g = 0; g < NREQ; g++) begin : g_chk
        a_no_underflow : assert property (@(posedge clk) disable iff (rst)
            !(fin_vld && fin_id == IDW'(g) && !gnt[g] && cnt_q[g] == '0));
        a_no_overflow : assert property (@(posedge clk) disable iff (rst)
            cnt_q[g] <= CW'(MAX_OUT));
    end
endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;
    localparam int NREQ    = 4;
    localparam int LAT     = 8;
    localparam int MAX_OUT = 3;
    localparam int IDW     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mul_n1;
    logic [7:0]  mul_n2;
    logic [15:0] mul_result;
    logic        busy;

    mult_share_arb_if #(.NREQ(NREQ)) bus ();

    mult_share_arb #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .mul_n1     (mul_n1),
        .mul_n2     (mul_n2),
        .mul_result (mul_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // unsigned A times signed B, 16-bit two's complement result
    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'($signed(b));
        return 16'(p);
    endfunction

    // Multiplier stand-in: LAT-deep pipeline, no reset, no stall.
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= prod(mul_n1, mul_n2);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_result = pipe[LAT-1];

    typedef struct { int id; logic [15:0] data; int due; } exp_t;
    typedef struct { int id; int n; } op_t;
    exp_t sb[$];
    op_t  hist[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit en     = 1'b0;
    int rr     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an op decided in cycle n is in flight in cycles
    // n+1 .. n+LAT+2 (last one = response cycle) and holds a credit in
    // cycles n+1 .. n+LAT+1.
    always @(negedge clk) begin
        if (en) begin
            int oc [NREQ];
            logic [NREQ-1:0] er;
            bit bexp;
            int g;
            int ix;
            exp_t keep[$];
            bexp = 1'b0;
            for (int i = 0; i < NREQ; i++) oc[i] = 0;
            foreach (hist[j]) begin
                if (hist[j].n < cyc && cyc <= hist[j].n + LAT + 2) bexp = 1'b1;
                if (hist[j].n < cyc && cyc <  hist[j].n + LAT + 2) oc[hist[j].id]++;
            end
            chk("busy", 32'(busy), 32'(bexp));
            er = '0;
            g  = -1;
            if (!rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    ix = (rr + k) % NREQ;
                    if (g < 0 && bus.req_valid[ix] && oc[ix] < MAX_OUT) g = ix;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            if (g >= 0) begin
                hist.push_back('{g, cyc});
                sb.push_back('{g, prod(bus.req_a[8*g +: 8], bus.req_b[8*g +: 8]), cyc + LAT + 2});
                rr = (g + 1) % NREQ;
            end
            if (rst) begin
                hist.delete();
                rr = 0;
                keep.delete();
                foreach (sb[j]) if (sb[j].due <= cyc) keep.push_back(sb[j]);
                sb = keep;
            end
            while (hist.size() > 0 && hist[0].n + LAT + 2 < cyc) void'(hist.pop_front());
        end
    end

    // Monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        if (en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.rsp_valid !== (4'b0001 << e.id) || bus.rsp_id !== IDW'(e.id) ||
                    bus.rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL rsp: got valid=%b id=%0d data=%h expected valid=%b id=%0d data=%h (cycle %0d)",
                             bus.rsp_valid, bus.rsp_id, bus.rsp_data, 4'b0001 << e.id, e.id, e.data, cyc);
                end
            end else begin
                chk("rsp_idle", 32'(bus.rsp_valid), 32'd0);
            end
        end
    end

    task automatic step(output logic [NREQ-1:0] xfer);
        @(negedge clk);
        xfer = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic new_ops(input int i);
        bus.req_a[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        bus.req_b[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    endtask

    task automatic wait_idle();
        logic [NREQ-1:0] x;
        int t;
        t = 0;
        while (busy && t < 60) begin
            step(x);
            t++;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] x;
        int t;
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a = {8'd40, 8'd30, 8'd20, 8'd5};
        bus.req_b = {8'd4, 8'd3, 8'd2, 8'hFD};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",   32'(bus.req_ready), 32'd0);
        chk("rst_rsp_vld", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy",    32'(busy),          32'd0);
        chk("rst_n1",      32'(mul_n1),        32'd0);
        chk("rst_n2",      32'(mul_n2),        32'd0);
        chk("rst_rsp_id",  32'(bus.rsp_id),    32'd0);
        chk("rst_rsp_dat", 32'(bus.rsp_data),  32'd0);
        en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("first_grant", 32'(bus.req_ready), 32'b0001);

        // single op: req0 5 * -3
        step(x);
        bus.req_valid = '0;
        t = 0;
        while (bus.rsp_valid == '0 && t < 20) begin
            step(x);
            t++;
        end
        chk("single_vld",  32'(bus.rsp_valid), 32'b0001);
        chk("single_id",   32'(bus.rsp_id),    32'd0);
        chk("single_data", 32'(bus.rsp_data),  32'hFFF1);
        wait_idle();

        // full load
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        repeat (32) begin
            step(x);
            for (int i = 0; i < NREQ; i++) if (x[i]) new_ops(i);
        end
        bus.req_valid = '0;
        wait_idle();

        // credit limit on requester 1
        bus.req_valid = 4'b0010;
        new_ops(1);
        repeat (30) begin
            step(x);
            if (x[1]) new_ops(1);
        end
        bus.req_valid = '0;
        wait_idle();

        // RR pointer: grant 2, then 3 must precede 0
        bus.req_valid = 4'b0100;
        new_ops(2);
        step(x);
        bus.req_valid = 4'b1001;
        new_ops(0);
        new_ops(3);
        #1 chk("rr_order", 32'(bus.req_ready), 32'b1000);
        step(x);
        step(x);
        bus.req_valid = 4'b0001;
        new_ops(0);
        #1 chk("rr_single", 32'(bus.req_ready), 32'b0001);
        repeat (4) begin
            step(x);
            if (x[0]) new_ops(0);
        end
        bus.req_valid = '0;
        wait_idle();

        // reset with two ops in flight on requester 0
        bus.req_valid = 4'b0001;
        new_ops(0);
        step(x);
        new_ops(0);
        step(x);
        bus.req_valid = '0;
        step(x);
        rst = 1'b1;
        step(x);
        rst = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_a[7:0] = 8'd200;
        bus.req_b[7:0] = 8'h80;
        #1 chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        step(x);
        bus.req_valid = '0;
        wait_idle();

        // randomized traffic
        repeat (400) begin
            step(x);
            for (int i = 0; i < NREQ; i++) begin
                if (!(bus.req_valid[i] && !x[i])) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    new_ops(i);
                end
            end
        end
        bus.req_valid = '0;
        wait_idle();
        step(x);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
